// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - rebuilds WIDTH-bit words from a sel-indexed serial stream into a 2-entry output buffer
module serial_deserializer #(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 8,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             sin,
    input  logic             VO,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             err_seq,
    output logic             ovf,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t             state;
    logic [SEL_W-1:0]   exp_idx;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   slot;
    logic               slot_valid;

    logic               sel_ok;
    logic               last_bit;
    logic               word_done;
    logic               pop;
    logic               push_ok;
    logic [WIDTH-1:0]   bit_word;
    logic [WIDTH-1:0]   done_word;

    // exp_idx is always below WIDTH, so an out-of-range sel can never match
    always_comb begin
        sel_ok    = 1'b0;
        last_bit  = 1'b0;
        bit_word  = '0;
        done_word = '0;
        word_done = 1'b0;
        pop       = 1'b0;
        push_ok   = 1'b0;
        if (state == RECV) begin
            sel_ok = (sel == exp_idx);
        end else begin
            sel_ok = (sel == '0);
        end
        last_bit  = (sel == SEL_W'(WIDTH - 1));
        bit_word  = WIDTH'(sin) << sel;
        done_word = shreg | bit_word;
        word_done = VO && sel_ok && last_bit;
        pop       = dout_valid && dout_ready;
        push_ok   = word_done && (!slot_valid || pop);
    end

    always_ff @(posedge ck) begin
        if (!reset) begin
            state      <= IDLE;
            exp_idx    <= '0;
            shreg      <= '0;
            slot       <= '0;
            slot_valid <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err_seq    <= 1'b0;
            ovf        <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            err_seq <= 1'b0;

            if (VO) begin
                if (sel_ok) begin
                    if (last_bit) begin
                        state   <= IDLE;
                        exp_idx <= '0;
                        shreg   <= '0;
                    end else begin
                        state   <= RECV;
                        exp_idx <= exp_idx + SEL_W'(1);
                        shreg   <= done_word;
                    end
                end else begin
                    err_seq <= 1'b1;
                    // a stray sel=0 is taken as the start of a fresh word
                    if (sel == '0) begin
                        state   <= RECV;
                        exp_idx <= SEL_W'(1);
                        shreg   <= bit_word;
                    end else begin
                        state   <= IDLE;
                        exp_idx <= '0;
                        shreg   <= '0;
                    end
                end
            end

            // dout is the head entry, slot the second; a pop shifts slot forward
            if (pop) begin
                if (slot_valid) begin
                    dout <= slot;
                    if (push_ok) begin
                        slot <= done_word;
                    end else begin
                        slot_valid <= 1'b0;
                    end
                end else begin
                    if (push_ok) begin
                        dout <= done_word;
                    end else begin
                        dout_valid <= 1'b0;
                    end
                end
            end else if (word_done) begin
                if (!dout_valid) begin
                    dout       <= done_word;
                    dout_valid <= 1'b1;
                end else if (!slot_valid) begin
                    slot       <= done_word;
                    slot_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end

            if (push_ok) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - vector table, directed sequences and random stimulus against a queue-based model
module tb_serial_deserializer;

    logic       ck = 1'b0;
    logic       reset = 1'b0;
    logic       sin = 1'b0;
    logic       VO = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       err_seq;
    logic       ovf;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    serial_deserializer #(.WIDTH(8), .CNT_W(8)) dut (
        .ck         (ck),
        .reset      (reset),
        .sin        (sin),
        .VO         (VO),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err_seq    (err_seq),
        .ovf        (ovf),
        .frame_cnt  (frame_cnt)
    );

    always #5 ck = ~ck;

    // model: bits of the word in progress, words waiting for the sink
    bit         m_bits[$];
    logic [7:0] m_obuf[$];
    logic       m_err;
    logic       m_ovf;
    logic [7:0] m_cnt;

    typedef struct {
        logic       vo;
        logic [2:0] sel;
        logic       sin;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_dout;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_obuf.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_edge(input logic vo, input logic [2:0] s, input logic b, input logic rdy);
        logic       pop;
        logic       push;
        logic [7:0] w;
        pop   = (m_obuf.size() > 0) && rdy;
        push  = 1'b0;
        w     = '0;
        m_err = 1'b0;
        if (vo) begin
            if (int'(s) == m_bits.size()) begin
                m_bits.push_back(b);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) w = w + (8'(m_bits[i]) << i);
                    push = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_err = 1'b1;
                m_bits.delete();
                if (s == 3'd0) m_bits.push_back(b);
            end
        end
        if (pop) void'(m_obuf.pop_front());
        if (push) begin
            if (m_obuf.size() < 2) begin
                m_obuf.push_back(w);
                m_cnt = m_cnt + 8'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        logic [7:0] exp_d;
        logic [7:0] act_d;
        exp_d = (m_obuf.size() > 0) ? m_obuf[0] : 8'h00;
        act_d = dout_valid ? dout : 8'h00;
        check("model", {act_d, 7'd0, dout_valid, 6'd0, err_seq, ovf, frame_cnt},
                       {exp_d, 7'd0, logic'(m_obuf.size() > 0), 6'd0, m_err, m_ovf, m_cnt});
    endtask

    task automatic step(input logic vo, input logic [2:0] s, input logic b, input logic rdy);
        VO = vo;
        sel = s;
        sin = b;
        dout_ready = rdy;
        @(posedge ck);
        #1;
        model_edge(vo, s, b, rdy);
        check_model();
    endtask

    task automatic send_word(input logic [7:0] w, input int gap_max, input logic rdy, output int errs);
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'(k), w[k], rdy);
            if (err_seq) errs++;
            if (k < 7 && gap_max > 0) begin
                for (int g = 0; g < int'($urandom_range(1, gap_max)); g++) begin
                    step(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), rdy);
                    if (err_seq) errs++;
                end
            end
        end
    endtask

    // reset is asserted with a valid-looking bit on the line to show reset takes priority
    task automatic do_reset();
        VO = 1'b1;
        sel = 3'd4;
        sin = 1'b1;
        dout_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        model_reset();
        check("rst_outputs", {dout, 7'd0, dout_valid, 6'd0, err_seq, ovf, frame_cnt}, 32'd0);
        reset = 1'b1;
        VO = 1'b0;
    endtask

    initial begin
        int         errs;
        logic [7:0] cnt_before;
        logic [7:0] w;

        // word 8'h4D, sel 0..7, sink always ready
        tbl[0] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[5] = '{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[6] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[7] = '{1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 8'h4D, 1'b0, 8'd1};
        tbl[8] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1};
        tbl[9] = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd1};

        model_reset();
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].vo, tbl[i].sel, tbl[i].sin, tbl[i].rdy);
            check("tbl_valid", 32'(dout_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) check("tbl_dout", 32'(dout), 32'(tbl[i].exp_dout));
            check("tbl_err", 32'(err_seq), 32'(tbl[i].exp_err));
            check("tbl_cnt", 32'(frame_cnt), 32'(tbl[i].exp_cnt));
        end

        // three back-to-back words into a stalled sink
        do_reset();
        send_word(8'hA5, 0, 1'b0, errs);
        send_word(8'h3C, 0, 1'b0, errs);
        send_word(8'hFF, 0, 1'b0, errs);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_cnt", 32'(frame_cnt), 32'd2);
        check("ovf_head", 32'(dout), 32'hA5);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("drain_second", {24'd0, dout}, 32'h3C);
        check("drain_valid1", 32'(dout_valid), 32'd1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("drain_empty", 32'(dout_valid), 32'd0);

        // out-of-order sel mid-word
        cnt_before = frame_cnt;
        step(1'b1, 3'd0, 1'b1, 1'b1);
        step(1'b1, 3'd1, 1'b1, 1'b1);
        step(1'b1, 3'd2, 1'b1, 1'b1);
        step(1'b1, 3'd5, 1'b1, 1'b1);
        check("seq_err_pulse", 32'(err_seq), 32'd1);
        check("seq_no_push", 32'(frame_cnt), 32'(cnt_before));
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("seq_err_clear", 32'(err_seq), 32'd0);
        send_word(8'h81, 0, 1'b1, errs);
        check("after_err_word", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h81});

        // sel=0 mid-word restarts
        w = 8'h3B;
        for (int k = 0; k < 4; k++) step(1'b1, 3'(k), 1'b0, 1'b1);
        step(1'b1, 3'd0, w[0], 1'b1);
        check("restart_err", 32'(err_seq), 32'd1);
        for (int k = 1; k < 8; k++) step(1'b1, 3'(k), w[k], 1'b1);
        check("restart_word", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h3B});

        // VO gaps between bits
        step(1'b0, 3'd0, 1'b0, 1'b1);
        send_word(8'h96, 3, 1'b1, errs);
        check("gap_no_err", 32'(errs), 32'd0);
        check("gap_word", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h96});

        // reset mid-word with a word buffered
        send_word(8'h55, 0, 1'b0, errs);
        for (int k = 0; k < 5; k++) step(1'b1, 3'(k), 1'b1, 1'b0);
        do_reset();
        send_word(8'h11, 0, 1'b1, errs);
        check("post_rst_word", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h11});
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);
        for (int n = 0; n < 255; n++) send_word(8'($urandom), 0, 1'b1, errs);
        check("cnt_wrap", 32'(frame_cnt), 32'd0);
        check("wrap_no_ovf", 32'(ovf), 32'd0);

        // random traffic, sel biased toward the expected index
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] s;
            if ($urandom_range(0, 9) < 8) s = 3'(m_bits.size());
            else s = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 3) != 0), s, 1'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
